umi_memtest: RTL and testbench
==============================

// Module: umi_memtest
// PURPOSE
// - UMI traffic source/checker directly upstream of the UMI RAM endpoint: drives its request port and consumes its read responses.
// - On start: writes a deterministic pattern to NUM_WORDS consecutive words, reads each back, compares, reports pass/fail.
// - Used as on-chip self-test and as the standalone stimulus for RAM endpoint simulations.
// PARAMETERS
// - ADDR_WIDTH     8                       word-address width of target; addresses wrap mod 2**ADDR_WIDTH
// - DATA_WIDTH     32                      word width; 8..256, power of two
// - NUM_WORDS      16                      words per run, 1..2**ADDR_WIDTH
// - SRC_ADDR       64'h0000_0000_CAFE_0000 srcaddr placed in requests; responses must carry it as dstaddr
// - SEED           32'h0000_0001           pattern seed
// - TIMEOUT_CYCLES 1024                    response watchdog limit (only with UMI_MEMTEST_TIMEOUT_EN)
// PORTS
// - clk            in  1   sole clock
// - rst            in  1   synchronous, active-high reset
// - start          in  1   1-cycle pulse; accepted in IDLE or DONE, ignored otherwise
// - base_addr      in  ADDR_WIDTH first word address of run
// - umi_tx_packet  out 256 request packet (umi_pack)
// - umi_tx_valid   out 1   request valid
// - umi_tx_ready   in  1   request accepted when valid&&ready at posedge
// - umi_rx_packet  in  256 response packet (umi_unpack)
// - umi_rx_valid   in  1   response valid
// - umi_rx_ready   out 1   response accept
// - busy           out 1   run in progress
// - done           out 1   run finished; held until next start or rst
// - pass           out 1   valid with done: err_count==0 and no timeout
// - err_count      out 16  mismatches + protocol errors, saturates at 16'hFFFF
// - first_err_addr out ADDR_WIDTH address of first error; 0 if none
// - timeout        out 1   watchdog fired (tied 0 without macro)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, index 0; rst mid-run aborts, umi_tx_valid drops at that edge, no pending response tracked.
// - FSM: IDLE -start-> WRITE -last write accepted-> RD_REQ -accepted-> RD_WAIT -response-> RD_REQ (more) | DONE (last). DONE -start-> WRITE.
// - start: clears err_count, first_err_addr, timeout, done, pass, index; busy=1 cycle after start.
// - addr(i) = (base_addr + i) mod 2**ADDR_WIDTH; dstaddr = zero-extended addr(i).
// - pattern(i) = (SEED ^ (i * 32'h9E37_79B9)) replicated/truncated to DATA_WIDTH; data upper bits zero.
// - Requests: WRITE_POSTED (WRITE) / READ_REQUEST (RD_REQ) from umi_messages.vh; size=$clog2(DATA_WIDTH/8); options 0; burst 0; srcaddr=SRC_ADDR.
// - tx handshake: packet stable while valid; change only after valid&&ready edge; back-to-back writes allowed (next packet the cycle after acceptance).
// - Exactly one read outstanding. umi_rx_ready=1 only in RD_WAIT; deasserts the cycle after a transfer.
// - Response check: opcode must be WRITE_RESPONSE and dstaddr==SRC_ADDR, else protocol error; else data[DATA_WIDTH-1:0] vs pattern(i), mismatch = error.
// - Any error: err_count+1 (saturating); first_err_addr latched on first error only; run continues, index advances.
// - Responses arriving outside RD_WAIT are not accepted (ready=0).
// - DONE: busy=0, done=1, pass=(err_count==0 && !timeout); outputs hold.
// - Latency: first request valid 1 cycle after start; done 1 cycle after last response accepted.
// CONFIGURATION
// - UMI_MEMTEST_TIMEOUT_EN defined: counter runs in RD_WAIT, reset per read request; reaching TIMEOUT_CYCLES -> timeout=1, rx_ready=0, state DONE, pass=0.
// - UMI_MEMTEST_TIMEOUT_EN undefined: no counter; RD_WAIT waits indefinitely; timeout tied 0.
// TESTING
// - Base 0, NUM_WORDS=16, RAM endpoint model -> 16 WRITE_POSTED then 16 READ_REQUEST, done=1, pass=1, err_count=0.
// - Responder flips data bit0 on addr 3 -> err_count=1, first_err_addr=3, pass=0, all 16 reads still issued.
// - base_addr=8'hF8 -> dstaddrs F8..FF,00..07 in order; pass=1.
// - umi_tx_ready held low 10 cycles mid-write -> packet unchanged, no duplicate or lost writes.
// - rst asserted during RD_WAIT -> next cycle all outputs 0; new start completes with pass=1.
// - Macro on, TIMEOUT_CYCLES=64, responder silent -> timeout=1, done=1 64 cycles after read acceptance; macro off -> busy stays 1.

Source files
------------

// File: rtl/umi_memtest.sv
// UMI memory self-test: writes a seeded pattern to NUM_WORDS words, reads each back and checks it.
// Optional response watchdog is enabled by defining UMI_MEMTEST_TIMEOUT_EN.
`timescale 1ns/1ps
module umi_memtest #(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_WORDS      = 16,
   parameter logic [63:0] SRC_ADDR       = 64'h0000_0000_CAFE_0000,
   parameter logic [31:0] SEED           = 32'h0000_0001,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic [255:0]          umi_tx_packet,
   output logic                  umi_tx_valid,
   input  logic                  umi_tx_ready,
   input  logic [255:0]          umi_rx_packet,
   input  logic                  umi_rx_valid,
   output logic                  umi_rx_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic                  timeout
);

   // state   | meaning
   // IDLE    | waiting for start after reset
   // WRITE   | posting pattern word index to addr(index)
   // RD_REQ  | issuing read request for addr(index)
   // RD_WAIT | one read outstanding, accepting its response
   // DONE    | run complete, results held until next start

   // Packet layout: cmd[31:0] = {burst[27:20], options[19:12], size[11:8], opcode[7:0]},
   // dstaddr[95:32], srcaddr[159:96], data[255:160].
   localparam int unsigned DF_W = (DATA_WIDTH > 96) ? 96 : DATA_WIDTH;
   localparam logic [95:0] DATA_MASK = (96'(1) << DF_W) - 96'(1);
   localparam logic [7:0]  OP_WRITE_POSTED   = 8'h01;
   localparam logic [7:0]  OP_READ_REQUEST   = 8'h08;
   localparam logic [7:0]  OP_WRITE_RESPONSE = 8'h09;
   localparam logic [3:0]  CMD_SIZE = 4'($clog2(DATA_WIDTH / 8));
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, DONE} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] index, base_q, addr_cur;
   logic                  tx_valid_c, rx_ready_c;
   logic                  run_start, idx_inc, idx_clr, rsp_take, tmr_load, to_fire;
   logic                  tmr_expired, last_idx, rsp_err;

   function automatic logic [95:0] pattern(input logic [ADDR_WIDTH-1:0] i);
      logic [31:0] p;
      logic [95:0] r;
      p = SEED ^ (32'(i) * 32'h9E37_79B9);
      r = '0;
      for (int b = 0; b < int'(DF_W); b++) r[b] = p[b % 32];
      return r;
   endfunction

   function automatic logic [255:0] pack(input logic [7:0] op, input logic [63:0] dst,
                                         input logic [95:0] data);
      logic [255:0] p;
      p          = '0;
      p[7:0]     = op;
      p[11:8]    = CMD_SIZE;
      p[95:32]   = dst;
      p[159:96]  = SRC_ADDR;
      p[255:160] = data;
      return p;
   endfunction

   assign addr_cur = base_q + index;
   assign last_idx = (index == LAST_IDX);

   assign rsp_err = (umi_rx_packet[7:0] != OP_WRITE_RESPONSE) ||
                    (umi_rx_packet[95:32] != SRC_ADDR) ||
                    (((umi_rx_packet[255:160] ^ pattern(index)) & DATA_MASK) != 96'd0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      tx_valid_c = 1'b0;
      rx_ready_c = 1'b0;
      run_start  = 1'b0;
      idx_inc    = 1'b0;
      idx_clr    = 1'b0;
      rsp_take   = 1'b0;
      tmr_load   = 1'b0;
      to_fire    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx  = WRITE;
               run_start = 1'b1;
            end
         end
         WRITE: begin
            tx_valid_c = 1'b1;
            if (umi_tx_ready) begin
               if (last_idx) begin
                  state_nx = RD_REQ;
                  idx_clr  = 1'b1;
               end else begin
                  idx_inc = 1'b1;
               end
            end
         end
         RD_REQ: begin
            tx_valid_c = 1'b1;
            if (umi_tx_ready) begin
               state_nx = RD_WAIT;
               tmr_load = 1'b1;
            end
         end
         RD_WAIT: begin
            rx_ready_c = 1'b1;
            // a response landing on the expiry cycle still counts
            if (umi_rx_valid) begin
               rsp_take = 1'b1;
               if (last_idx) begin
                  state_nx = DONE;
               end else begin
                  state_nx = RD_REQ;
                  idx_inc  = 1'b1;
               end
            end else if (tmr_expired) begin
               to_fire  = 1'b1;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         index          <= '0;
         base_q         <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         if (run_start) begin
            index          <= '0;
            base_q         <= base_addr;
            err_count      <= '0;
            first_err_addr <= '0;
         end else if (idx_clr) begin
            index <= '0;
         end else if (idx_inc) begin
            index <= index + 1'b1;
         end
         if (rsp_take && rsp_err) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0)    first_err_addr <= addr_cur;
         end
      end
   end

`ifdef UMI_MEMTEST_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] tmr;
   logic             timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr       <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (tmr_load)                              tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
         else if (state == RD_WAIT && tmr != '0)    tmr <= tmr - 1'b1;
         if (run_start)    timeout_q <= 1'b0;
         else if (to_fire) timeout_q <= 1'b1;
      end
   end

   assign tmr_expired = (tmr == '0);
   assign timeout     = timeout_q;
`else
   localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_tmr;
   assign unused_tmr  = tmr_load ^ to_fire;
   assign tmr_expired = 1'b0;
   assign timeout     = 1'b0;
`endif

   assign umi_tx_valid  = tx_valid_c;
   assign umi_rx_ready  = rx_ready_c;
   assign umi_tx_packet = (state == WRITE)  ? pack(OP_WRITE_POSTED, 64'(addr_cur), pattern(index)) :
                          (state == RD_REQ) ? pack(OP_READ_REQUEST, 64'(addr_cur), 96'd0) :
                                              256'd0;
   assign busy = (state == WRITE) || (state == RD_REQ) || (state == RD_WAIT);
   assign done = (state == DONE);
   assign pass = (state == DONE) && (err_count == 16'd0) && !timeout;

endmodule

// File: tb/tb_umi_memtest.sv
// Bench for umi_memtest: RAM endpoint model plus request scoreboard and result checks.
`timescale 1ns/1ps
module tb_umi_memtest;
   localparam logic [63:0] SRC  = 64'h0000_0000_CAFE_0000;
   localparam logic [31:0] SEED = 32'h0000_0001;
   localparam int          NW   = 16;
   localparam logic [7:0]  WP = 8'h01, RR = 8'h08, WR = 8'h09;

   logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0]   base_addr = 8'h00;
   logic [255:0] umi_tx_packet;
   logic         umi_tx_valid;
   logic         umi_tx_ready = 1'b1;
   logic [255:0] umi_rx_packet = '0;
   logic         umi_rx_valid = 1'b0;
   logic         umi_rx_ready;
   logic         busy, done, pass, timeout;
   logic [15:0]  err_count;
   logic [7:0]   first_err_addr;

   always #5 clk = ~clk;

   umi_memtest #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(NW), .SRC_ADDR(SRC),
                 .SEED(SEED), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .umi_tx_packet(umi_tx_packet), .umi_tx_valid(umi_tx_valid), .umi_tx_ready(umi_tx_ready),
      .umi_rx_packet(umi_rx_packet), .umi_rx_valid(umi_rx_valid), .umi_rx_ready(umi_rx_ready),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err_addr(first_err_addr), .timeout(timeout));

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {logic [7:0] op; logic [63:0] dst; logic [31:0] data;} req_t;
   req_t         exp_q[$];
   logic [255:0] rsp_q[$];
   logic [31:0]  mem [256];
   bit           flip3 = 0, silent = 0, stall_en = 0, stall_done = 0, rx_acc = 0, hold_pend = 0;
   int           stall_cnt = 0, n_wr = 0, n_rd = 0, rsp_wait = 0, rsp_lat = 2;
   logic [255:0] hold_pkt;
   longint       last_rd_time = 0;

   function automatic logic [31:0] pat(input int i);
      return SEED ^ (32'(i) * 32'h9E37_79B9);
   endfunction

   // Endpoint: inputs change on the falling edge, so what is seen here is what the next rising edge samples.
   always @(negedge clk) begin
      req_t e;
      logic [255:0] r;
      logic [7:0] a;
      if (!rst) begin
         if (stall_en && !stall_done && n_wr == 5) begin
            stall_cnt  = 10;
            stall_done = 1;
         end
         if (stall_cnt > 0) begin
            umi_tx_ready = 1'b0;
            stall_cnt--;
         end else begin
            umi_tx_ready = 1'b1;
         end
         if (hold_pend) begin
            chk("tx_hold_valid", umi_tx_valid, 1);
            chk("tx_hold_pkt", umi_tx_packet, hold_pkt);
         end
         if (umi_tx_valid && !umi_tx_ready) begin
            if (!hold_pend) hold_pkt = umi_tx_packet;
            hold_pend = 1;
         end else begin
            hold_pend = 0;
         end
         if (umi_tx_valid && umi_tx_ready) begin
            if (exp_q.size() == 0) begin
               chk("tx_extra_request", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("tx_cmd", umi_tx_packet[31:0], {20'h0, 4'd2, e.op});
               chk("tx_dstaddr", umi_tx_packet[95:32], e.dst);
               chk("tx_srcaddr", umi_tx_packet[159:96], SRC);
               chk("tx_data", umi_tx_packet[255:160], {64'h0, e.data});
            end
            a = umi_tx_packet[39:32];
            if (umi_tx_packet[7:0] == WP) begin
               mem[a] = umi_tx_packet[191:160];
               n_wr++;
            end else begin
               n_rd++;
               last_rd_time = $time;
               r = '0;
               r[7:0] = WR;
               r[11:8] = 4'd2;
               r[95:32] = SRC;
               r[159:96] = umi_tx_packet[95:32];
               r[191:160] = mem[a] ^ ((flip3 && a == 8'd3) ? 32'd1 : 32'd0);
               rsp_q.push_back(r);
            end
         end
         if (rx_acc) begin
            chk("rx_ready_drop", umi_rx_ready, 0);
            umi_rx_valid = 1'b0;
            rx_acc = 0;
         end
         if (!umi_rx_valid && rsp_q.size() > 0 && !silent) begin
            if (rsp_wait >= rsp_lat) begin
               umi_rx_packet = rsp_q.pop_front();
               umi_rx_valid  = 1'b1;
               rsp_wait      = 0;
            end else begin
               rsp_wait++;
            end
         end
         if (umi_rx_valid && umi_rx_ready) rx_acc = 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] b);
      for (int i = 0; i < NW; i++) exp_q.push_back('{WP, 64'(8'(b + i)), pat(i)});
      for (int i = 0; i < NW; i++) exp_q.push_back('{RR, 64'(8'(b + i)), 32'd0});
   endtask

   task automatic kick(input logic [7:0] b, input string nm);
      push_exp(b);
      n_wr = 0;
      n_rd = 0;
      base_addr = b;
      start = 1'b1;
      tick;
      start = 1'b0;
      chk({nm, "_busy_after_start"}, busy, 1);
      chk({nm, "_tx_valid_latency"}, umi_tx_valid, 1);
   endtask

   task automatic run(input logic [7:0] b, input string nm, input bit exp_pass,
                      input logic [15:0] exp_errs, input logic [7:0] exp_first);
      int cyc;
      kick(b, nm);
      cyc = 0;
      while (!done && cyc < 3000) begin
         tick;
         cyc++;
      end
      chk({nm, "_done"}, done, 1);
      chk({nm, "_busy_low"}, busy, 0);
      chk({nm, "_pass"}, pass, exp_pass);
      chk({nm, "_err_count"}, err_count, exp_errs);
      chk({nm, "_first_err_addr"}, first_err_addr, exp_first);
      chk({nm, "_timeout"}, timeout, 0);
      chk({nm, "_writes"}, n_wr, NW);
      chk({nm, "_reads"}, n_rd, NW);
      chk({nm, "_sb_left"}, exp_q.size(), 0);
      tick;
      tick;
      chk({nm, "_done_hold"}, {done, pass}, {1'b1, exp_pass});
   endtask

   task automatic flush;
      exp_q.delete();
      rsp_q.delete();
      umi_rx_valid = 1'b0;
      rx_acc = 0;
      hold_pend = 0;
      rsp_wait = 0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_tx_valid"}, umi_tx_valid, 0);
      chk({nm, "_tx_packet"}, umi_tx_packet, 0);
      chk({nm, "_rx_ready"}, umi_rx_ready, 0);
      chk({nm, "_flags"}, {busy, done, pass, timeout}, 0);
      chk({nm, "_err_count"}, err_count, 0);
      chk({nm, "_first_err_addr"}, first_err_addr, 0);
   endtask

   initial begin
      int cyc;
      longint lat;
      for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
      repeat (3) tick;
      chk_zero("reset");
      rst = 1'b0;
      tick;

      run(8'h00, "basic", 1, 16'd0, 8'h00);

      flip3 = 1;
      run(8'h00, "flip3", 0, 16'd1, 8'h03);
      flip3 = 0;

      run(8'hF8, "wrap", 1, 16'd0, 8'h00);

      stall_en = 1;
      stall_done = 0;
      run(8'h20, "stall", 1, 16'd0, 8'h00);
      chk("stall_happened", stall_done, 1);
      stall_en = 0;

      rsp_lat = 6;
      kick(8'h40, "midrst");
      cyc = 0;
      while (!(umi_rx_ready && n_rd == 3) && cyc < 1000) begin
         tick;
         cyc++;
      end
      chk("midrst_reached_rd_wait", umi_rx_ready, 1);
      rst = 1'b1;
      tick;
      chk_zero("midrst");
      rst = 1'b0;
      flush;
      rsp_lat = 2;
      tick;
      run(8'h40, "after_rst", 1, 16'd0, 8'h00);

      silent = 1;
      kick(8'h00, "silent");
      cyc = 0;
`ifdef UMI_MEMTEST_TIMEOUT_EN
      while (!done && cyc < 1000) begin
         tick;
         cyc++;
      end
      lat = (($time - 1) - (last_rd_time + 5)) / 10;
      chk("silent_done", done, 1);
      chk("silent_timeout", timeout, 1);
      chk("silent_pass", pass, 0);
      chk("silent_latency", lat, 64);
      chk("silent_rx_ready", umi_rx_ready, 0);
`else
      while (cyc < 300) begin
         tick;
         cyc++;
      end
      chk("silent_busy", busy, 1);
      chk("silent_done", done, 0);
      chk("silent_timeout", timeout, 0);
      chk("silent_rx_ready", umi_rx_ready, 1);
      chk("silent_one_read", n_rd, 1);
`endif
      rst = 1'b1;
      tick;
      rst = 1'b0;
      silent = 0;
      flush;
      tick;
      chk_zero("final_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
